// File: rtl/pe_result_writer.sv
// pe_result_writer
// Captures the PE array accumulator vector into a shadow register on acc_done,
// then streams it to the result SRAM as NUM_BEATS beats of BEAT_ELEMS lanes at
// consecutive addresses starting from base_addr. The PE core is free to start
// the next pass as soon as the capture has happened.
//
// Ports:
//   clk          system clock, rising edge
//   srst         synchronous active-high reset
//   acc_done     single-cycle pulse, mul_outcome final this cycle
//   mul_outcome  packed accumulators, element 0 at the MSB end
//   base_addr    first SRAM address, sampled with acc_done
//   sram_wready  SRAM write grant (beat completes on sram_wen && sram_wready)
//   sram_wen     write request
//   sram_waddr   write address
//   sram_wdata   beat data, lane l at [l*OUTCOME_WIDTH +: OUTCOME_WIDTH]
//   busy         high while not idle
//   wb_done      single-cycle pulse after the last beat is accepted
//   overrun_err  sticky, acc_done seen while busy
module pe_result_writer #(
    parameter int unsigned ARRAY_SIZE    = 32,
    parameter int unsigned OUTCOME_WIDTH = 32,
    parameter int unsigned BEAT_ELEMS    = 4,
    parameter int unsigned ADDR_WIDTH    = 10
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                acc_done,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic                                sram_wready,
    output logic                                sram_wen,
    output logic [ADDR_WIDTH-1:0]               sram_waddr,
    output logic [BEAT_ELEMS*OUTCOME_WIDTH-1:0] sram_wdata,
    output logic                                busy,
    output logic                                wb_done,
    output logic                                overrun_err
);

    localparam int unsigned NUM_BEATS = ARRAY_SIZE / BEAT_ELEMS;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned EIDX_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int unsigned BEAT_W    = BEAT_ELEMS * OUTCOME_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic [OUTCOME_WIDTH-1:0] r_shadow [ARRAY_SIZE];
    logic                     r_wen;
    logic [ADDR_WIDTH-1:0]    r_waddr;
    logic [BEAT_W-1:0]        r_wdata;
    logic                     r_busy;
    logic                     r_wb_done;
    logic                     r_overrun;

    logic [OUTCOME_WIDTH-1:0] w_in_elem [ARRAY_SIZE];
    logic [BEAT_W-1:0]        w_first_beat;
    logic [BEAT_W-1:0]        w_next_beat;
    logic [CNT_W-1:0]         w_next_cnt;
    logic                     w_last;

    // Unpack the MSB-first input vector into ascending element order.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_unpack
        assign w_in_elem[j] = mul_outcome[(ARRAY_SIZE-j)*OUTCOME_WIDTH-1 -: OUTCOME_WIDTH];
    end

    assign w_next_cnt = r_beat_cnt + CNT_W'(1);
    assign w_last     = (r_beat_cnt == LAST_BEAT);

    // Beat 0 comes straight from the input (shadow not loaded yet); later
    // beats are pre-fetched from the shadow one beat ahead so the output
    // data register is ready the cycle the previous beat is accepted.
    for (genvar l = 0; l < BEAT_ELEMS; l++) begin : g_lane
        assign w_first_beat[l*OUTCOME_WIDTH +: OUTCOME_WIDTH] = w_in_elem[l];
        assign w_next_beat[l*OUTCOME_WIDTH +: OUTCOME_WIDTH] =
            r_shadow[EIDX_W'(32'(w_next_cnt) * BEAT_ELEMS + 32'(l))];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_wb_done  <= 1'b0;
            r_overrun  <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wb_done <= 1'b0;
                    if (acc_done) begin
                        r_shadow   <= w_in_elem;
                        r_waddr    <= base_addr;
                        r_wdata    <= w_first_beat;
                        r_beat_cnt <= '0;
                        r_wen      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (acc_done) begin
                        r_overrun <= 1'b1;
                    end
                    // Without a grant everything holds (stall).
                    if (sram_wready) begin
                        r_beat_cnt <= w_next_cnt;
                        if (w_last) begin
                            r_wen     <= 1'b0;
                            r_wb_done <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_waddr <= r_waddr + ADDR_WIDTH'(1);
                            r_wdata <= w_next_beat;
                        end
                    end
                end
                S_DONE: begin
                    if (acc_done) begin
                        r_overrun <= 1'b1;
                    end
                    r_wb_done <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wen   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_wen    = r_wen;
    assign sram_waddr  = r_waddr;
    assign sram_wdata  = r_wdata;
    assign busy        = r_busy;
    assign wb_done     = r_wb_done;
    assign overrun_err = r_overrun;

endmodule
